microwave_power_controller: RTL and testbench

- Second-generation single-clock microwave controller: keypad time entry, power-level duty cycling, pause/resume, quick-start/+30 s and an end-of-cook beep.
- Integrates the keypad entry, magnetron control and BCD down-counter functions in one synchronous FSM.
- Outputs raw BCD digits for the existing 7-segment driver; the display driver stays outside this block.
- Minutes digit count, clock rate, duty window and beep length are parameters.

---
 rtl/microwave_power_controller.sv | 274 +++++++++++++++++++++++++++
 tb/tb_microwave_power_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_power_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : microwave_power_controller                                      |
// | Purpose  : Keypad time entry, power duty cycling, pause/resume, +30 s and  |
// |            end-of-cook beep in one synchronous FSM with BCD countdown.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module microwave_power_controller #(
  parameter int CLK_HZ      = 100,
  parameter int MIN_DIGITS  = 1,
  parameter int DUTY_WINDOW = 10,
  parameter int BEEP_S      = 3
) (
  input  logic                    clock,
  input  logic                    clrn,
  input  logic [9:0]              keypad,
  input  logic                    key_power,
  input  logic                    startn,
  input  logic                    stopn,
  input  logic                    clearn,
  input  logic                    door_closed,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic [3:0]              power_level,
  output logic                    mag_on,
  output logic                    cooking,
  output logic                    done_beep
);
  localparam int MW    = 4 * MIN_DIGITS;
  localparam int TW    = MW + 8;
  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int PH_W  = (DUTY_WINDOW > 1) ? $clog2(DUTY_WINDOW) : 1;
  localparam int BP_W  = (BEEP_S > 1) ? $clog2(BEEP_S) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_HZ - 1);
  localparam logic [PH_W-1:0]  PH_MAX   = PH_W'(DUTY_WINDOW - 1);
  localparam logic [BP_W-1:0]  BP_MAX   = BP_W'(BEEP_S - 1);
  localparam logic [MW-1:0]    MINS_MAX = {MIN_DIGITS{4'h9}};
  localparam logic [TW-1:0]    TIME_30S = {{MW{1'b0}}, 8'h30};

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_POWER_SET, S_COOK, S_PAUSED, S_DONE
  } state_t;

  state_t           state_q, state_d, ret_q, ret_d;
  logic [TW-1:0]    time_q, time_d, t_next;
  logic [3:0]       power_q, power_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [BP_W-1:0]  beep_q, beep_d;
  logic             mag_on_q, mag_on_d, cooking_q, cooking_d, done_beep_q, done_beep_d;
  logic             startn_q, stopn_q, key_power_q;
  logic [9:0]       keypad_q;
  logic [3:0]       key_val;
  logic             start_ev, stop_ev, pwr_ev, key_ev, clr, tick, fresh_cook;

  function automatic logic [MW-1:0] mins_dec(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          borrow;
    r      = m;
    borrow = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (borrow) begin
        if (m[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = m[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Returns {carry_out, incremented minutes}
  function automatic logic [MW:0] mins_inc(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          carry;
    r     = m;
    carry = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (carry) begin
        if (m[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = m[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return {carry, r};
  endfunction

  function automatic logic [TW-1:0] time_dec(input logic [TW-1:0] t);
    logic [MW-1:0] m;
    logic [3:0]    tn, o;
    {m, tn, o} = t;
    if (o != 4'd0) o = o - 4'd1;
    else begin
      o = 4'd9;
      if (tn != 4'd0) tn = tn - 4'd1;
      else begin
        tn = 4'd5;
        m  = mins_dec(m);
      end
    end
    return {m, tn, o};
  endfunction

  function automatic logic [TW-1:0] time_add30(input logic [TW-1:0] t);
    logic [MW-1:0] m;
    logic [3:0]    tn, o;
    logic [MW:0]   inc;
    {m, tn, o} = t;
    inc = mins_inc(m);
    if (tn < 4'd3) tn = tn + 4'd3;
    else if (inc[MW]) begin
      m  = MINS_MAX;
      tn = 4'd5;
      o  = 4'd9;
    end else begin
      m  = inc[MW-1:0];
      tn = tn - 4'd3;
    end
    return {m, tn, o};
  endfunction

  always_comb begin
    key_val = 4'd0;
    for (int i = 0; i < 10; i++) if (keypad[i]) key_val = 4'(i);
  end

  assign start_ev = ~startn & startn_q;
  assign stop_ev  = ~stopn & stopn_q;
  assign pwr_ev   = key_power & ~key_power_q;
  assign key_ev   = (keypad_q == 10'd0) && (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
  assign clr      = ~clearn;
  assign tick     = (div_q == DIV_MAX);

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    time_d  = time_q;
    power_d = power_q;
    t_next  = time_q;
    // Decrement first, then +30 s, so a coincident tick is never lost
    if (state_q == S_COOK && tick)     t_next = time_dec(time_q);
    if (state_q == S_COOK && start_ev) t_next = time_add30(t_next);

    if (clr) begin
      state_d = S_IDLE;
      time_d  = '0;
      power_d = 4'd10;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (stop_ev) begin
          end else if (start_ev) begin
            if (door_closed) begin
              time_d  = TIME_30S;
              state_d = S_COOK;
            end
          end else if (pwr_ev) begin
            ret_d   = S_IDLE;
            state_d = S_POWER_SET;
          end else if (key_ev) begin
            time_d  = {{(TW-4){1'b0}}, key_val};
            state_d = S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (stop_ev) begin
          end else if (start_ev) begin
            if (door_closed && time_q != '0) state_d = S_COOK;
          end else if (pwr_ev) begin
            ret_d   = S_ENTRY;
            state_d = S_POWER_SET;
          end else if (key_ev) begin
            time_d = {time_q[TW-5:0], key_val};
          end
        end
        S_POWER_SET: begin
          if (key_ev) begin
            power_d = (key_val == 4'd0) ? 4'd10 : key_val;
            state_d = ret_q;
          end
        end
        S_COOK: begin
          if (stop_ev || !door_closed) state_d = S_PAUSED;
          else begin
            time_d = t_next;
            if (t_next == '0) state_d = S_DONE;
          end
        end
        S_PAUSED: begin
          if (stop_ev) begin
            state_d = S_IDLE;
            time_d  = '0;
          end else if (start_ev && door_closed) state_d = S_COOK;
        end
        S_DONE: begin
          if (stop_ev || start_ev || pwr_ev || key_ev) state_d = S_IDLE;
          else if (tick && beep_q == BP_MAX)           state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    div_d      = div_q;
    phase_d    = phase_q;
    beep_d     = beep_q;
    fresh_cook = (state_d == S_COOK) && (state_q == S_IDLE || state_q == S_ENTRY);
    // Transitions not listed here (notably into/out of PAUSED) hold the divider and phase
    if (fresh_cook) begin
      div_d   = '0;
      phase_d = '0;
    end else if (state_d == S_DONE && state_q != S_DONE) begin
      div_d  = '0;
      beep_d = '0;
    end else if (state_d == state_q && (state_q == S_COOK || state_q == S_DONE)) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick && state_q == S_COOK) phase_d = (phase_q == PH_MAX) ? '0 : phase_q + 1'b1;
      if (tick && state_q == S_DONE) beep_d = beep_q + 1'b1;
    end
    cooking_d   = (state_d == S_COOK);
    done_beep_d = (state_d == S_DONE);
    mag_on_d    = cooking_d && door_closed
                  && (int'(phase_d) < (int'(power_d) * DUTY_WINDOW) / 10);
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      time_q      <= '0;
      power_q     <= 4'd10;
      div_q       <= '0;
      phase_q     <= '0;
      beep_q      <= '0;
      mag_on_q    <= 1'b0;
      cooking_q   <= 1'b0;
      done_beep_q <= 1'b0;
      startn_q    <= 1'b1;
      stopn_q     <= 1'b1;
      key_power_q <= 1'b0;
      keypad_q    <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      time_q      <= time_d;
      power_q     <= power_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      beep_q      <= beep_d;
      mag_on_q    <= mag_on_d;
      cooking_q   <= cooking_d;
      done_beep_q <= done_beep_d;
      startn_q    <= startn;
      stopn_q     <= stopn;
      key_power_q <= key_power;
      keypad_q    <= keypad;
    end
  end

  assign sec_ones    = time_q[3:0];
  assign sec_tens    = time_q[7:4];
  assign mins        = time_q[TW-1:8];
  assign power_level = power_q;
  assign mag_on      = mag_on_q;
  assign cooking     = cooking_q;
  assign done_beep   = done_beep_q;

endmodule
`default_nettype wire

// File: tb/tb_microwave_power_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_microwave_power_controller                                   |
// | Purpose  : Directed vector table plus multi-cycle cooking sequences.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_microwave_power_controller;
  localparam int CLK_HZ      = 100;
  localparam int MIN_DIGITS  = 1;
  localparam int DUTY_WINDOW = 10;
  localparam int BEEP_S      = 3;

  logic       clock = 1'b0;
  logic       clrn = 1'b0;
  logic [9:0] keypad = '0;
  logic       key_power = 1'b0, startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b1;
  logic [3:0] sec_ones, sec_tens, power_level;
  logic [4*MIN_DIGITS-1:0] mins;
  logic       mag_on, cooking, done_beep;

  int checks = 0;
  int errors = 0;

  microwave_power_controller #(
    .CLK_HZ(CLK_HZ), .MIN_DIGITS(MIN_DIGITS), .DUTY_WINDOW(DUTY_WINDOW), .BEEP_S(BEEP_S)
  ) dut (
    .clock(clock), .clrn(clrn), .keypad(keypad), .key_power(key_power),
    .startn(startn), .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins), .power_level(power_level),
    .mag_on(mag_on), .cooking(cooking), .done_beep(done_beep)
  );

  always #5 clock = ~clock;

  // ctl = {key_power, startn, stopn, clearn, door_closed}; disp = {mins, tens, ones}
  typedef struct packed {
    logic [9:0]  key;
    logic [4:0]  ctl;
    logic [11:0] disp;
    logic [3:0]  pw;
    logic        ck;
  } vec_t;

  vec_t tbl [30];

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] disp();
    return {mins, sec_tens, sec_ones};
  endfunction

  function automatic logic [2:0] stat();
    return {cooking, mag_on, done_beep};
  endfunction

  task automatic key(input int d);
    keypad = 10'(1 << d);
    cyc(1);
    keypad = '0;
    cyc(1);
  endtask

  task automatic press_power();
    key_power = 1'b1;
    cyc(1);
    key_power = 1'b0;
    cyc(1);
  endtask

  task automatic press_start();
    startn = 1'b0;
    cyc(1);
    startn = 1'b1;
  endtask

  task automatic press_stop();
    stopn = 1'b0;
    cyc(1);
    stopn = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{10'h000, 5'b01111, 12'h000, 4'd10, 1'b0};
    tbl[1]  = '{10'h002, 5'b01111, 12'h001, 4'd10, 1'b0};
    tbl[2]  = '{10'h002, 5'b01111, 12'h001, 4'd10, 1'b0};
    tbl[3]  = '{10'h000, 5'b01111, 12'h001, 4'd10, 1'b0};
    tbl[4]  = '{10'h018, 5'b01111, 12'h001, 4'd10, 1'b0};
    tbl[5]  = '{10'h000, 5'b01111, 12'h001, 4'd10, 1'b0};
    tbl[6]  = '{10'h080, 5'b01111, 12'h017, 4'd10, 1'b0};
    tbl[7]  = '{10'h000, 5'b01111, 12'h017, 4'd10, 1'b0};
    tbl[8]  = '{10'h004, 5'b01111, 12'h172, 4'd10, 1'b0};
    tbl[9]  = '{10'h000, 5'b01111, 12'h172, 4'd10, 1'b0};
    tbl[10] = '{10'h100, 5'b01111, 12'h728, 4'd10, 1'b0};
    tbl[11] = '{10'h000, 5'b01111, 12'h728, 4'd10, 1'b0};
    tbl[12] = '{10'h000, 5'b11111, 12'h728, 4'd10, 1'b0};
    tbl[13] = '{10'h000, 5'b01111, 12'h728, 4'd10, 1'b0};
    tbl[14] = '{10'h010, 5'b01111, 12'h728, 4'd4,  1'b0};
    tbl[15] = '{10'h000, 5'b01111, 12'h728, 4'd4,  1'b0};
    tbl[16] = '{10'h000, 5'b11111, 12'h728, 4'd4,  1'b0};
    tbl[17] = '{10'h000, 5'b01111, 12'h728, 4'd4,  1'b0};
    tbl[18] = '{10'h001, 5'b01111, 12'h728, 4'd10, 1'b0};
    tbl[19] = '{10'h000, 5'b01111, 12'h728, 4'd10, 1'b0};
    tbl[20] = '{10'h000, 5'b11111, 12'h728, 4'd10, 1'b0};
    tbl[21] = '{10'h000, 5'b01111, 12'h728, 4'd10, 1'b0};
    tbl[22] = '{10'h040, 5'b01111, 12'h728, 4'd6,  1'b0};
    tbl[23] = '{10'h000, 5'b01111, 12'h728, 4'd6,  1'b0};
    tbl[24] = '{10'h020, 5'b01111, 12'h285, 4'd6,  1'b0};
    tbl[25] = '{10'h000, 5'b01110, 12'h285, 4'd6,  1'b0};
    tbl[26] = '{10'h000, 5'b00110, 12'h285, 4'd6,  1'b0};
    tbl[27] = '{10'h000, 5'b01110, 12'h285, 4'd6,  1'b0};
    tbl[28] = '{10'h000, 5'b00101, 12'h000, 4'd10, 1'b0};
    tbl[29] = '{10'h000, 5'b01111, 12'h000, 4'd10, 1'b0};

    #12;
    check("reset_disp",  {20'd0, disp()}, 32'h000);
    check("reset_power", {28'd0, power_level}, 32'd10);
    check("reset_stat",  {29'd0, stat()}, 32'd0);
    clrn = 1'b1;
    cyc(1);

    for (int i = 0; i < 30; i++) begin
      keypad = tbl[i].key;
      {key_power, startn, stopn, clearn, door_closed} = tbl[i].ctl;
      cyc(1);
      check($sformatf("vec%0d", i), {15'd0, disp(), power_level, cooking},
            {15'd0, tbl[i].disp, tbl[i].pw, tbl[i].ck});
    end

    // 1:30 full cook, then beep window
    key(1); key(3); key(0);
    check("entry_130", {20'd0, disp()}, 32'h130);
    press_start();
    check("cook_start_stat", {29'd0, stat()}, 32'b110);
    cyc(99);  check("cook_99",  {20'd0, disp()}, 32'h130);
    cyc(1);   check("cook_100", {20'd0, disp()}, 32'h129);
    cyc(8899); check("cook_8999", {20'd0, disp()}, 32'h001);
    check("cook_8999_stat", {29'd0, stat()}, 32'b110);
    cyc(1);   check("done_stat", {29'd0, stat()}, 32'b001);
    check("done_disp", {20'd0, disp()}, 32'h000);
    cyc(299); check("beep_299", {29'd0, stat()}, 32'b001);
    cyc(1);   check("beep_end", {29'd0, stat()}, 32'b000);

    // power 3 duty cycle on 0:20
    press_power(); key(3);
    check("power3", {28'd0, power_level}, 32'd3);
    key(2); key(0);
    press_start();
    check("duty_s0", {31'd0, mag_on}, 32'd1);
    cyc(299); check("duty_s2", {31'd0, mag_on}, 32'd1);
    cyc(1);   check("duty_s3", {31'd0, mag_on}, 32'd0);
    cyc(699); check("duty_s9", {31'd0, mag_on}, 32'd0);
    cyc(1);   check("duty_wrap", {31'd0, mag_on}, 32'd1);
    check("duty_disp10", {20'd0, disp()}, 32'h010);
    cyc(999); check("duty_disp01", {20'd0, disp()}, 32'h001);
    cyc(1);   check("duty_done", {29'd0, stat()}, 32'b001);
    press_stop();
    check("done_abort", {29'd0, stat()}, 32'b000);

    // clear in ENTRY restores power 10; door pause/resume at 0:45
    key(1);
    clearn = 1'b0; cyc(1); clearn = 1'b1;
    check("clear_power", {28'd0, power_level}, 32'd10);
    check("clear_disp",  {20'd0, disp()}, 32'h000);
    key(4); key(5);
    press_start();
    cyc(40);
    door_closed = 1'b0;
    cyc(1);
    check("door_stat", {29'd0, stat()}, 32'b000);
    check("door_disp", {20'd0, disp()}, 32'h045);
    cyc(5); door_closed = 1'b1; cyc(2);
    press_start();
    check("resume_stat", {29'd0, stat()}, 32'b110);
    cyc(59); check("resume_59", {20'd0, disp()}, 32'h045);
    cyc(1);  check("resume_60", {20'd0, disp()}, 32'h044);
    press_stop(); cyc(1); press_stop();
    check("cancel_disp", {20'd0, disp()}, 32'h000);

    // quick-start and +30 s
    press_start();
    check("quick_disp", {20'd0, disp()}, 32'h030);
    check("quick_stat", {29'd0, stat()}, 32'b110);
    cyc(1800); check("quick_012", {20'd0, disp()}, 32'h012);
    press_start(); check("plus30", {20'd0, disp()}, 32'h042);
    cyc(98); check("plus30_hold", {20'd0, disp()}, 32'h042);
    cyc(1);  check("plus30_tick", {20'd0, disp()}, 32'h041);
    press_stop(); cyc(1); press_stop();

    // saturation with one minutes digit
    key(9); key(4); key(5);
    check("entry_945", {20'd0, disp()}, 32'h945);
    press_start(); cyc(1); press_start();
    check("sat_959", {20'd0, disp()}, 32'h959);
    press_stop(); cyc(1); press_stop();

    // stop coinciding with tick at 0:05
    key(0); key(6);
    press_start();
    cyc(100); check("st_005", {20'd0, disp()}, 32'h005);
    cyc(99);
    press_stop();
    check("st_pause_disp", {20'd0, disp()}, 32'h005);
    check("st_pause_stat", {29'd0, stat()}, 32'b000);
    cyc(1); press_stop();
    check("st_idle_disp",  {20'd0, disp()}, 32'h000);
    check("st_idle_power", {28'd0, power_level}, 32'd10);

    // asynchronous reset mid-cook
    press_power(); key(5);
    press_start();
    check("ar_power5", {28'd0, power_level}, 32'd5);
    cyc(50);
    #3 clrn = 1'b0;
    #1;
    check("ar_stat",  {29'd0, stat()}, 32'b000);
    check("ar_disp",  {20'd0, disp()}, 32'h000);
    check("ar_power", {28'd0, power_level}, 32'd10);
    #2 clrn = 1'b1;
    cyc(2);
    check("ar_idle", {29'd0, stat()}, 32'b000);
    key(2);
    check("ar_entry", {20'd0, disp()}, 32'h002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
